mem_bus_master: RTL and testbench

MEM_BUS_MASTER -- requirements
Module: mem_bus_master

---
 rtl/mem_bus_pkg.sv | 22 ++
 rtl/mem_bus_master.sv | 118 +++++++++++
 tb/tb_mem_bus_master.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_pkg
// Description : Shared types and default sizes for the memory bus master:
//               FSM state encoding and default address/data widths.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

    localparam int c_default_awidth = 5;
    localparam int c_default_dwidth = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

endpackage : mem_bus_pkg
`default_nettype wire

// File: rtl/mem_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_master
// Description : Request/response front end for an asynchronous-style SRAM on
//               a shared bidirectional data bus. Writes take one bus cycle;
//               reads take an address cycle, a data cycle and a response
//               cycle. All outputs are registered; only the mem_data
//               tristate enable is decoded from registered strobes.
// Config      : MEM_BUS_MASTER_RSP_READY_EN - adds rsp_ready and holds the
//               response until it is accepted. Undefined: rsp_valid is a
//               one-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int AWIDTH = c_default_awidth,
    parameter int DWIDTH = c_default_dwidth
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
`ifdef MEM_BUS_MASTER_RSP_READY_EN
    input  logic              rsp_ready,
`endif
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [AWIDTH-1:0] mem_addr,
    inout  wire  [DWIDTH-1:0] mem_data
);

    state_t              r_state;
    state_t              w_state_next;
    logic [DWIDTH-1:0]   r_wdata;

    logic                w_accept;
    logic                w_req_ready_next;
    logic                w_rsp_valid_next;
    logic                w_mem_wr_next;
    logic                w_mem_rd_next;
    logic [AWIDTH-1:0]   w_mem_addr_next;
    logic [DWIDTH-1:0]   w_wdata_next;
    logic [DWIDTH-1:0]   w_rsp_rdata_next;

    // req_ready is a registered copy of (state == IDLE), so this is the handshake
    assign w_accept = (r_state == ST_IDLE) && req_valid;

    // The master owns the bus only while strobing a write
    assign mem_data = (mem_wr && !mem_rd) ? r_wdata : {DWIDTH{1'bz}};

    // State register and registered outputs; reset abandons any transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_wdata   <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            mem_wr    <= 1'b0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
        end else begin
            r_state   <= w_state_next;
            r_wdata   <= w_wdata_next;
            req_ready <= w_req_ready_next;
            rsp_valid <= w_rsp_valid_next;
            rsp_rdata <= w_rsp_rdata_next;
            mem_wr    <= w_mem_wr_next;
            mem_rd    <= w_mem_rd_next;
            mem_addr  <= w_mem_addr_next;
        end
    end

    // Next-state logic: requests are only taken in IDLE, never queued
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_next = req_we ? ST_WRITE : ST_RD_ADDR;
                end
            end
            ST_WRITE:   w_state_next = ST_IDLE;
            ST_RD_ADDR: w_state_next = ST_RD_DATA;
            ST_RD_DATA: w_state_next = ST_RESP;
            ST_RESP: begin
`ifdef MEM_BUS_MASTER_RSP_READY_EN
                if (rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
`else
                w_state_next = ST_IDLE;
`endif
            end
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Output decode from the next state so every strobe lines up with its state
    always_comb begin
        w_req_ready_next = (w_state_next == ST_IDLE);
        w_mem_wr_next    = (w_state_next == ST_WRITE);
        w_mem_rd_next    = (w_state_next == ST_RD_ADDR) || (w_state_next == ST_RD_DATA);
        w_rsp_valid_next = (w_state_next == ST_RESP);
        w_mem_addr_next  = w_accept ? req_addr : mem_addr;
        w_wdata_next     = (w_accept && req_we) ? req_wdata : r_wdata;
        // Memory presents data during RD_DATA; capture it as that cycle ends
        w_rsp_rdata_next = (r_state == ST_RD_DATA) ? mem_data : rsp_rdata;
    end

endmodule : mem_bus_master
`default_nettype wire

// File: tb/tb_mem_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_master
// Description : Self-checking bench for mem_bus_master with a 32x8 memory
//               model on the shared data bus and a scoreboard memory that
//               predicts read data from the accepted request stream.
// Config      : MEM_BUS_MASTER_RSP_READY_EN - also exercises response stall.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [4:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       mem_wr;
    logic       mem_rd;
    logic [4:0] mem_addr;
    wire  [7:0] mem_data;
`ifdef MEM_BUS_MASTER_RSP_READY_EN
    logic       rsp_ready;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_bus_master #(.AWIDTH(5), .DWIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
`ifdef MEM_BUS_MASTER_RSP_READY_EN
        .rsp_ready (rsp_ready),
`endif
        .mem_wr    (mem_wr),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data)
    );

    // 32x8 synchronous memory: registers read data, drives the bus while mem_rd
    logic [7:0] mem_arr [32] = '{default: 8'h00};
    logic [7:0] mem_q = 8'h00;
    assign mem_data = mem_rd ? mem_q : 8'bz;
    always @(posedge clk) begin
        if (mem_wr) mem_arr[mem_addr] <= mem_data;
        if (mem_rd) mem_q <= mem_arr[mem_addr];
    end

    // Scoreboard: what memory should hold, derived only from accepted requests
    logic [7:0] model_mem [32] = '{default: 8'h00};

    // Bus event log for ordering checks
    typedef struct packed {
        logic       we;
        logic [4:0] addr;
        logic [7:0] data;
    } bus_ev_t;
    bus_ev_t    bus_q[$];
    logic [7:0] rsp_q[$];
    logic       prev_rd  = 1'b0;
    logic       prev_rsp = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Whole-run bus monitor: contention check plus event logging
    always @(negedge clk) begin
        if (!rst) begin
            check("no_wr_and_rd", {31'd0, mem_wr & mem_rd}, 32'd0);
            if (mem_wr) bus_q.push_back({1'b1, mem_addr, mem_data});
            if (mem_rd && !prev_rd) bus_q.push_back({1'b0, mem_addr, 8'h00});
            if (rsp_valid && !prev_rsp) rsp_q.push_back(rsp_rdata);
        end
        prev_rd  = mem_rd;
        prev_rsp = rsp_valid;
    end

    // One complete transaction with cycle-accurate expectations
    task automatic do_txn(input logic we, input logic [4:0] addr, input logic [7:0] wd,
                          input logic [7:0] exp_rd);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("req_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (we) begin
            model_mem[addr] = wd;
            check("wr_strobe",      {31'd0, mem_wr}, 32'd1);
            check("wr_no_rd",       {31'd0, mem_rd}, 32'd0);
            check("wr_addr",        {27'd0, mem_addr}, {27'd0, addr});
            check("wr_data",        {24'd0, mem_data}, {24'd0, wd});
            check("wr_busy",        {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
            check("wr_done",        {31'd0, mem_wr}, 32'd0);
            check("wr_ready_again", {31'd0, req_ready}, 32'd1);
            check("wr_addr_hold",   {27'd0, mem_addr}, {27'd0, addr});
        end else begin
            check("rd_addr_rd",     {31'd0, mem_rd}, 32'd1);
            check("rd_addr_addr",   {27'd0, mem_addr}, {27'd0, addr});
            check("rd_addr_busy",   {31'd0, req_ready}, 32'd0);
            check("rd_addr_novld",  {31'd0, rsp_valid}, 32'd0);
            @(posedge clk); #1;
            check("rd_data_rd",     {31'd0, mem_rd}, 32'd1);
            check("rd_data_addr",   {27'd0, mem_addr}, {27'd0, addr});
            check("rd_data_novld",  {31'd0, rsp_valid}, 32'd0);
            @(posedge clk); #1;
            check("rsp_valid",      {31'd0, rsp_valid}, 32'd1);
            check("rsp_rdata",      {24'd0, rsp_rdata}, {24'd0, exp_rd});
            check("rsp_rd_low",     {31'd0, mem_rd}, 32'd0);
            @(posedge clk); #1;
            check("rsp_pulse",      {31'd0, rsp_valid}, 32'd0);
            check("rsp_hold",       {24'd0, rsp_rdata}, {24'd0, exp_rd});
            check("rd_ready_again", {31'd0, req_ready}, 32'd1);
        end
    endtask

    typedef struct {
        logic       we;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    initial begin
        vec_t       vecs [6];
        int         acc_cyc [4];
        bus_ev_t    exp_ev  [4];
        logic [4:0] ra;
        logic       rw;
        logic [7:0] rd;
        int         idx;
        int         n;

        vecs[0] = '{1'b1, 5'd3,  8'hA5, 8'h00};
        vecs[1] = '{1'b0, 5'd3,  8'h00, 8'hA5};
        vecs[2] = '{1'b1, 5'd0,  8'h11, 8'h00};
        vecs[3] = '{1'b1, 5'd31, 8'h22, 8'h00};
        vecs[4] = '{1'b0, 5'd31, 8'h00, 8'h22};
        vecs[5] = '{1'b0, 5'd0,  8'h00, 8'h11};

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
`ifdef MEM_BUS_MASTER_RSP_READY_EN
        rsp_ready = 1'b1;
`endif
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_wr",    {31'd0, mem_wr}, 32'd0);
        check("rst_mem_rd",    {31'd0, mem_rd}, 32'd0);
        check("rst_mem_addr",  {27'd0, mem_addr}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Directed vector table
        for (int i = 0; i < 6; i++)
            do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);

        // Request during reset is not accepted
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd7; req_wdata = 8'h77;
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_req_no_wr", {31'd0, mem_wr}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_req_no_wr_after", {31'd0, mem_wr}, 32'd0);
        check("rst_req_ready",       {31'd0, req_ready}, 32'd1);
        do_txn(1'b0, 5'd7, 8'h00, model_mem[7]);

        // Reset during RD_DATA abandons the read
        do_txn(1'b1, 5'd5, 8'h5C, 8'h00);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_in_rd_data", {31'd0, mem_rd}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_mem_wr",    {31'd0, mem_wr}, 32'd0);
        check("midrst_mem_rd",    {31'd0, mem_rd}, 32'd0);
        check("midrst_mem_addr",  {27'd0, mem_addr}, 32'd0);
        check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midrst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        check("midrst_ready",     {31'd0, req_ready}, 32'd1);
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            check("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        do_txn(1'b0, 5'd5, 8'h00, 8'h5C);

        // req_valid held high across four alternating requests
        bus_q.delete(); rsp_q.delete();
        exp_ev[0] = {1'b1, 5'd10, 8'h3C};
        exp_ev[1] = {1'b0, 5'd10, 8'h00};
        exp_ev[2] = {1'b1, 5'd11, 8'hC3};
        exp_ev[3] = {1'b0, 5'd11, 8'h00};
        @(negedge clk);
        idx = 0; n = 0;
        req_valid = 1'b1; req_we = exp_ev[0].we; req_addr = exp_ev[0].addr; req_wdata = exp_ev[0].data;
        while (idx < 4 && n < 60) begin
            n++;
            if (req_ready) begin
                @(posedge clk); #1;
                acc_cyc[idx] = cyc;
                check("held_busy", {31'd0, req_ready}, 32'd0);
                idx++;
                if (idx < 4) begin
                    req_we = exp_ev[idx].we; req_addr = exp_ev[idx].addr; req_wdata = exp_ev[idx].data;
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        check("held_all_accepted", idx, 32'd4);
        repeat (4) @(negedge clk);
        if (idx == 4) begin
            check("held_gap_w_r", acc_cyc[1] - acc_cyc[0], 32'd2);
            check("held_gap_r_w", acc_cyc[2] - acc_cyc[1], 32'd4);
            check("held_gap_w_r2", acc_cyc[3] - acc_cyc[2], 32'd2);
        end
        check("held_bus_events", bus_q.size(), 32'd4);
        check("held_rsp_count",  rsp_q.size(), 32'd2);
        for (int i = 0; i < 4; i++)
            if (i < bus_q.size()) check("held_bus_order", {18'd0, bus_q[i]}, {18'd0, exp_ev[i]});
        if (rsp_q.size() == 2) begin
            check("held_rsp0", {24'd0, rsp_q[0]}, 32'h3C);
            check("held_rsp1", {24'd0, rsp_q[1]}, 32'hC3);
        end
        model_mem[10] = 8'h3C;
        model_mem[11] = 8'hC3;

`ifdef MEM_BUS_MASTER_RSP_READY_EN
        // Response stalled by rsp_ready=0
        do_txn(1'b1, 5'd9, 8'h9E, 8'h00);
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd9;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("stall_valid0", {31'd0, rsp_valid}, 32'd1);
        check("stall_data0",  {24'd0, rsp_rdata}, 32'h9E);
        repeat (5) begin
            @(posedge clk); #1;
            check("stall_valid", {31'd0, rsp_valid}, 32'd1);
            check("stall_data",  {24'd0, rsp_rdata}, 32'h9E);
            check("stall_busy",  {31'd0, req_ready}, 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_release_ready", {31'd0, req_ready}, 32'd1);
        check("stall_release_valid", {31'd0, rsp_valid}, 32'd0);
`endif

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 60; i++) begin
            rw = 1'($urandom_range(0, 1));
            ra = 5'($urandom_range(0, 31));
            rd = 8'($urandom);
            do_txn(rw, ra, rd, model_mem[ra]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global guard so the run always ends
    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout: cycle %0d reached without completion", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mem_bus_master
`default_nettype wire
